dmem_bridge: RTL and testbench

//  Downstream stage of dcache: serves its mem_* port (single reads, bursts, word writes) from a

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_valid_pipe.sv | 29 ++
 rtl/dmem_bridge.sv | 169 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dcache-side SRAM bridge.
// FSM state encoding, read-latency ceiling and burst-length width.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } dmem_state_e;

  localparam int unsigned MAX_RD_LATENCY = 4;
  localparam int unsigned BURSTLEN_BITS  = 16;

  // A zero-length burst still returns one word.
  function automatic logic [BURSTLEN_BITS-1:0] burst_words(input logic [BURSTLEN_BITS-1:0] len);
    return (len == '0) ? BURSTLEN_BITS'(1) : len;
  endfunction

endpackage

// File: rtl/dmem_valid_pipe.sv
// Shift register tracking in-flight SRAM reads; the last stage lines up with sram_rdata.
// Depth RD_LATENCY+1 covers the registered SRAM strobe plus the SRAM read latency.
module dmem_valid_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic flush,
  input  logic strobe_in,
  output logic strobe_out,
  output logic empty,
  output logic empty_next
);

  logic [RD_LATENCY:0] pipe_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[RD_LATENCY-1:0], strobe_in};
    end
  end

  assign strobe_out = pipe_q[RD_LATENCY];
  assign empty      = ~|pipe_q;
  // Empty next cycle provided no new strobe enters; only the tail may still be set.
  assign empty_next = ~|pipe_q[RD_LATENCY-1:0];

endmodule

// File: rtl/dmem_bridge.sv
// Serves dcache mem_* requests (word writes, single reads, bursts) from a synchronous SRAM.
// Optional DMEM_BRIDGE_STATS_EN adds saturating read-word/write/burst counters.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned DATABITS      = 32,
  parameter int unsigned ADDRBITS      = 32,
  parameter int unsigned SRAM_ADDRBITS = 9,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRBITS-1:0]      mem_addr,
  input  logic [DATABITS-1:0]      mem_in,
  output logic [DATABITS-1:0]      mem_out,
  output logic                     mem_out_valid,
  input  logic                     mem_rdreq,
  input  logic                     mem_wrreq,
  input  logic [BURSTLEN_BITS-1:0] mem_burstlen,
  output logic                     mem_ready,
  output logic [SRAM_ADDRBITS-1:0] sram_addr,
  output logic [DATABITS-1:0]      sram_wdata,
  output logic                     sram_we,
  output logic                     sram_en,
`ifdef DMEM_BRIDGE_STATS_EN
  output logic [31:0]              stat_rdwords,
  output logic [31:0]              stat_wrwords,
  output logic [15:0]              stat_bursts,
`endif
  input  logic [DATABITS-1:0]      sram_rdata
);

  dmem_state_e state_q, state_d;

  logic [SRAM_ADDRBITS-1:0] addr_q, addr_d;
  logic [BURSTLEN_BITS-1:0] remain_q, remain_d;
  logic [SRAM_ADDRBITS-1:0] word_addr, issue_addr;
  logic                     rd_issue, wr_issue;
  logic                     pipe_out, pipe_empty, pipe_empty_next;

  logic [SRAM_ADDRBITS-1:0] sram_addr_q;
  logic [DATABITS-1:0]      sram_wdata_q;
  logic                     sram_we_q, sram_en_q;
  logic [DATABITS-1:0]      mem_out_q;
  logic                     mem_out_valid_q;

  assign word_addr = mem_addr[SRAM_ADDRBITS+1:2];

  logic unused_addr;
  assign unused_addr = ^{mem_addr[ADDRBITS-1:SRAM_ADDRBITS+2], mem_addr[1:0]};

  assign mem_ready = !reset && (state_q == StIdle) && pipe_empty;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    rd_issue   = 1'b0;
    wr_issue   = 1'b0;
    issue_addr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (mem_ready) begin
          if (mem_wrreq) begin
            wr_issue   = 1'b1;
            issue_addr = word_addr;
          end else if (mem_rdreq) begin
            // First word goes out on acceptance; the rest stream from READ.
            rd_issue   = 1'b1;
            issue_addr = word_addr;
            addr_d     = word_addr + SRAM_ADDRBITS'(1);
            remain_d   = burst_words(mem_burstlen) - BURSTLEN_BITS'(1);
            state_d    = (remain_d == '0) ? StDrain : StRead;
          end
        end
      end
      StRead: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + SRAM_ADDRBITS'(1);
        remain_d = remain_q - BURSTLEN_BITS'(1);
        if (remain_q == BURSTLEN_BITS'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pipe_empty_next) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remain_q        <= '0;
      sram_addr_q     <= '0;
      sram_wdata_q    <= '0;
      sram_we_q       <= 1'b0;
      sram_en_q       <= 1'b0;
      mem_out_q       <= '0;
      mem_out_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      sram_en_q       <= rd_issue | wr_issue;
      sram_we_q       <= wr_issue;
      mem_out_valid_q <= pipe_out;
      if (rd_issue || wr_issue) begin
        sram_addr_q <= issue_addr;
      end
      if (wr_issue) begin
        sram_wdata_q <= mem_in;
      end
      if (pipe_out) begin
        mem_out_q <= sram_rdata;
      end
    end
  end

  dmem_valid_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_valid_pipe (
    .clk       (clk),
    .flush     (reset),
    .strobe_in (rd_issue),
    .strobe_out(pipe_out),
    .empty     (pipe_empty),
    .empty_next(pipe_empty_next)
  );

  assign sram_addr     = sram_addr_q;
  assign sram_wdata    = sram_wdata_q;
  assign sram_we       = sram_we_q;
  assign sram_en       = sram_en_q;
  assign mem_out       = mem_out_q;
  assign mem_out_valid = mem_out_valid_q;

`ifdef DMEM_BRIDGE_STATS_EN
  logic [31:0] stat_rdwords_q, stat_wrwords_q;
  logic [15:0] stat_bursts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rdwords_q <= '0;
      stat_wrwords_q <= '0;
      stat_bursts_q  <= '0;
    end else begin
      if (pipe_out && (stat_rdwords_q != '1)) begin
        stat_rdwords_q <= stat_rdwords_q + 32'd1;
      end
      if (wr_issue && (stat_wrwords_q != '1)) begin
        stat_wrwords_q <= stat_wrwords_q + 32'd1;
      end
      if (rd_issue && (state_q == StIdle) && (stat_bursts_q != '1)) begin
        stat_bursts_q <= stat_bursts_q + 16'd1;
      end
    end
  end

  assign stat_rdwords = stat_rdwords_q;
  assign stat_wrwords = stat_wrwords_q;
  assign stat_bursts  = stat_bursts_q;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: two instances (read latency 1 and 4) share one driver.
// Expected SRAM accesses and read words are queued at issue and popped by negedge monitors.
module tb_dmem_bridge;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } acc_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] addr_s, din_s;
  logic        rdreq_s, wrreq_s;
  logic [15:0] blen_s;

  logic [31:0] addr1, din1, addr4, din4;
  logic        rdreq1, wrreq1, rdreq4, wrreq4;
  logic [15:0] blen1, blen4;
  logic [31:0] out1, out4, wd1, wd4, rdata1, rdata4;
  logic        valid1, valid4, ready1, ready4, we1, we4, en1, en4;
  logic [8:0]  saddr1, saddr4;

  logic [31:0] ref_mem[512];
  logic [31:0] sram1[512];
  logic [31:0] sram4[512];
  logic [31:0] rpipe1;
  logic [31:0] rpipe4[4];

  rd_exp_t  rd_q[$];
  acc_exp_t acc_q[$];
  rd_exp_t  mon_rd;
  acc_exp_t mon_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign addr1  = sel ? 32'h0 : addr_s;
  assign din1   = sel ? 32'h0 : din_s;
  assign rdreq1 = sel ? 1'b0 : rdreq_s;
  assign wrreq1 = sel ? 1'b0 : wrreq_s;
  assign blen1  = sel ? 16'h0 : blen_s;
  assign addr4  = sel ? addr_s : 32'h0;
  assign din4   = sel ? din_s : 32'h0;
  assign rdreq4 = sel ? rdreq_s : 1'b0;
  assign wrreq4 = sel ? wrreq_s : 1'b0;
  assign blen4  = sel ? blen_s : 16'h0;

  logic        mem_ready, mo_valid, acc_en, acc_we;
  logic [31:0] mo_out, acc_wd;
  logic [8:0]  acc_addr;
  assign mem_ready = sel ? ready4 : ready1;
  assign mo_valid  = sel ? valid4 : valid1;
  assign mo_out    = sel ? out4 : out1;
  assign acc_en    = sel ? en4 : en1;
  assign acc_we    = sel ? we4 : we1;
  assign acc_addr  = sel ? saddr4 : saddr1;
  assign acc_wd    = sel ? wd4 : wd1;

`ifdef DMEM_BRIDGE_STATS_EN
  logic [31:0] st_rd1, st_wr1, st_rd4, st_wr4;
  logic [15:0] st_b1, st_b4;
`endif

  dmem_bridge #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_addr(addr1), .mem_in(din1), .mem_out(out1),
    .mem_out_valid(valid1), .mem_rdreq(rdreq1), .mem_wrreq(wrreq1), .mem_burstlen(blen1),
    .mem_ready(ready1), .sram_addr(saddr1), .sram_wdata(wd1), .sram_we(we1), .sram_en(en1),
`ifdef DMEM_BRIDGE_STATS_EN
    .stat_rdwords(st_rd1), .stat_wrwords(st_wr1), .stat_bursts(st_b1),
`endif
    .sram_rdata(rdata1)
  );

  dmem_bridge #(.RD_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .mem_addr(addr4), .mem_in(din4), .mem_out(out4),
    .mem_out_valid(valid4), .mem_rdreq(rdreq4), .mem_wrreq(wrreq4), .mem_burstlen(blen4),
    .mem_ready(ready4), .sram_addr(saddr4), .sram_wdata(wd4), .sram_we(we4), .sram_en(en4),
`ifdef DMEM_BRIDGE_STATS_EN
    .stat_rdwords(st_rd4), .stat_wrwords(st_wr4), .stat_bursts(st_b4),
`endif
    .sram_rdata(rdata4)
  );

  // SRAM models: contents preset on the first edge, read data delayed by the instance latency.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 512; i++) begin
        sram1[i] <= 32'hA5A5_0000 | i;
        sram4[i] <= 32'hA5A5_0000 | i;
      end
    end else begin
      if (en1 && we1) sram1[saddr1] <= wd1;
      if (en4 && we4) sram4[saddr4] <= wd4;
    end
    rpipe1    <= sram1[saddr1];
    rpipe4[0] <= sram4[saddr4];
    for (int k = 1; k < 4; k++) rpipe4[k] <= rpipe4[k-1];
  end
  assign rdata1 = rpipe1;
  assign rdata4 = rpipe4[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat();
    return sel ? 4 : 1;
  endfunction

  // Read-word monitor
  initial forever begin
    @(negedge clk);
    if (mo_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got mem_out %h with no word expected (cycle %0d)",
                 mo_out, cyc);
      end else begin
        mon_rd = rd_q.pop_front();
        check("rd_cycle", cyc, mon_rd.cyc);
        check("rd_data", mo_out, mon_rd.data);
      end
    end
  end

  // SRAM access monitor
  initial forever begin
    @(negedge clk);
    if (acc_en === 1'b1) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: got sram_addr %h we %b with none expected (cycle %0d)",
                 acc_addr, acc_we, cyc);
      end else begin
        mon_acc = acc_q.pop_front();
        check("acc_cycle", cyc, mon_acc.cyc);
        check("acc_we", {31'h0, acc_we}, {31'h0, mon_acc.we});
        check("acc_addr", {23'h0, acc_addr}, {23'h0, mon_acc.addr});
        if (mon_acc.we) check("acc_wdata", acc_wd, mon_acc.wdata);
      end
    end
  end

  task automatic wait_ready(output int t);
    int n;
    n = 0;
    #1;
    while (mem_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_ready", {31'h0, mem_ready}, 32'h1);
    t = cyc;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int t;
    acc_exp_t c;
    addr_s = a; din_s = d; wrreq_s = 1'b1; rdreq_s = 1'b0;
    wait_ready(t);
    c = '{t + 1, 1'b1, a[10:2], d};
    acc_q.push_back(c);
    ref_mem[a[10:2]] = d;
    @(negedge clk);
    wrreq_s = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [15:0] len, output int t);
    int n;
    logic [8:0] w;
    rd_exp_t r;
    acc_exp_t c;
    addr_s = a; blen_s = len; rdreq_s = 1'b1; wrreq_s = 1'b0;
    wait_ready(t);
    n = (len == 16'h0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      w = a[10:2] + 9'(i);
      c = '{t + 1 + i, 1'b0, w, 32'h0};
      acc_q.push_back(c);
      r = '{t + lat() + 2 + i, ref_mem[w]};
      rd_q.push_back(r);
    end
    @(negedge clk);
    rdreq_s = 1'b0;
    while (cyc < t + n + lat()) @(negedge clk);
    #1 check("busy_last", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    #1 check("ready_back", {31'h0, mem_ready}, 32'h1);
  endtask

  task automatic do_read_abort(input logic [31:0] a, input logic [15:0] len, input int k);
    int t;
    acc_exp_t c;
    addr_s = a; blen_s = len; rdreq_s = 1'b1; wrreq_s = 1'b0;
    wait_ready(t);
    for (int i = 0; i < k; i++) begin
      c = '{t + 1 + i, 1'b0, a[10:2] + 9'(i), 32'h0};
      acc_q.push_back(c);
    end
    @(negedge clk);
    rdreq_s = 1'b0;
    while (cyc < t + k) @(negedge clk);
    reset = 1'b1;
    #1 check("abort_ready_low", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    check("abort_valid_low", {31'h0, mo_valid}, 32'h0);
    reset = 1'b0;
    #1 check("ready_after_abort", {31'h0, mem_ready}, 32'h1);
    repeat (lat() + 6) @(negedge clk);
  endtask

  task automatic run_phase(input logic [31:0] dbase);
    int t, t2;
    for (int i = 0; i < 8; i++) begin
      check("wr_b2b_ready", {31'h0, mem_ready}, 32'h1);
      do_write(32'h80 + 32'(4 * i), dbase + 32'(i));
    end
    do_read(32'h80, 16'd8, t);
    do_read(32'h84, 16'd0, t);
    do_read(32'h7f8, 16'd4, t);
    // Write and read requested together: write goes first, read the next cycle.
    addr_s = 32'h100; din_s = dbase + 32'h0100_0000; blen_s = 16'd1;
    wrreq_s = 1'b1; rdreq_s = 1'b1;
    wait_ready(t);
    acc_q.push_back('{t + 1, 1'b1, 9'h040, din_s});
    ref_mem[9'h040] = din_s;
    @(negedge clk);
    wrreq_s = 1'b0;
    do_read(32'h100, 16'd1, t2);
    check("rd_after_wr_cycle", t2, t + 1);
    do_read_abort(32'h80, 16'd8, 2);
    do_write(32'h200, dbase + 32'h55);
    do_read(32'h200, 16'd3, t);
    @(negedge clk);
`ifdef DMEM_BRIDGE_STATS_EN
    check("stat_rdwords", sel ? st_rd4 : st_rd1, 32'd3);
    check("stat_wrwords", sel ? st_wr4 : st_wr1, 32'd1);
    check("stat_bursts", {16'h0, sel ? st_b4 : st_b1}, 32'd1);
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'hA5A5_0000 | i;
    addr_s = '0; din_s = '0; rdreq_s = 1'b0; wrreq_s = 1'b0; blen_s = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_ready4", {31'h0, ready4}, 32'h0);
    check("rst_mem_out", mo_out, 32'h0);
    check("rst_valid", {31'h0, mo_valid}, 32'h0);
    check("rst_sram_en", {31'h0, en1}, 32'h0);
    check("rst_sram_we", {31'h0, we1}, 32'h0);
    check("rst_sram_addr", {23'h0, saddr1}, 32'h0);
    check("rst_sram_wdata", wd1, 32'h0);
    reset = 1'b0;
    #1 check("ready_after_reset", {31'h0, mem_ready}, 32'h1);
    run_phase(32'h0fff_0001);
    @(negedge clk);
    sel = 1'b1;
    run_phase(32'h0fff_0101);
    repeat (10) @(negedge clk);
    check("rd_queue_empty", rd_q.size(), 32'h0);
    check("acc_queue_empty", acc_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to have finished",
             cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
